// File: rtl/rf_pkg.sv
// Shared helpers and default-width types for the multi-port register file.
package rf_pkg;

  localparam int unsigned RF_ZERO_DEFAULT = 31;

  function automatic int unsigned rf_aw(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  typedef logic [rf_aw(32)-1:0] rf_addr_t;
  typedef logic [63:0]          rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One read port: out-of-range / zero-register / write-first bypass select, then
// registered data with enable-hold and a one-cycle valid flag.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned HAS_ZERO = 1,
  parameter int unsigned ZERO_IDX = DEPTH - 1,
  parameter int unsigned AW       = rf_aw(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [AW-1:0]                 rd_addr,
  input  logic [WIDTH-1:0]              mem_data,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid
);

  logic [WIDTH-1:0] sel;

  // Ascending scan lets the highest-indexed matching write port win the bypass.
  always_comb begin
    sel = '0;
    if (32'(rd_addr) >= DEPTH) begin
      sel = '0;
    end else if ((HAS_ZERO != 0) && (32'(rd_addr) == ZERO_IDX)) begin
      sel = '0;
    end else begin
      sel = mem_data;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j] == rd_addr)) sel = wr_data[j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= sel;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: storage with prioritised writes,
// NUM_RD registered read ports with write-first bypass.
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int unsigned WIDTH    = 64,
  parameter  int unsigned DEPTH    = 32,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned NUM_WR   = 1,
  parameter  int unsigned HAS_ZERO = 1,
  parameter  int unsigned ZERO_IDX = DEPTH - 1,
  localparam int unsigned AW       = rf_aw(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD-1:0]             rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]             rd_valid,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic wr_legal(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((HAS_ZERO != 0) && (32'(a) == ZERO_IDX));
  endfunction

  // Later ports overwrite earlier ones in the same edge, so the highest index wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_legal(wr_addr[j])) mem[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [WIDTH-1:0] mem_data;

    assign mem_data = (32'(rd_addr[gi]) < DEPTH) ? mem[rd_addr[gi]] : '0;

    rf_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .NUM_WR   (NUM_WR),
      .HAS_ZERO (HAS_ZERO),
      .ZERO_IDX (ZERO_IDX),
      .AW       (AW)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en[gi]),
      .rd_addr  (rd_addr[gi]),
      .mem_data (mem_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[gi]),
      .rd_valid (rd_valid[gi])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream and are
// checked every cycle against a behavioural model plus literal expectations.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       rd_en;
  logic [1:0][4:0]  rd_addr;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][63:0] wr_data;

  logic [1:0][63:0] rdd [3];
  logic [1:0]       rdv [3];

  // k=0: DEPTH 32 zero reg 31; k=1: DEPTH 32 no zero reg; k=2: DEPTH 24 zero reg 23
  int unsigned dep [3] = '{32, 32, 24};
  int unsigned hz  [3] = '{1, 0, 1};
  int unsigned zi  [3] = '{31, 31, 23};

  regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .HAS_ZERO(1), .ZERO_IDX(31)) u_a (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]),
    .rd_valid(rdv[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
  regfile_mp #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .HAS_ZERO(0), .ZERO_IDX(31)) u_b (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]),
    .rd_valid(rdv[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
  regfile_mp #(.WIDTH(64), .DEPTH(24), .NUM_RD(2), .NUM_WR(2), .HAS_ZERO(1), .ZERO_IDX(23)) u_c (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[2]),
    .rd_valid(rdv[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  int errors = 0;
  int checks = 0;

  logic [63:0] mm [3][32];
  logic [63:0] ed [3][2];
  logic        ev [3][2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal(input int k, input logic [4:0] a);
    int unsigned ai;
    ai = a;
    return (ai < dep[k]) && !(hz[k] != 0 && ai == zi[k]);
  endfunction

  // Value a read of address a sees this edge: range, zero reg, newest write, storage.
  function automatic logic [63:0] mval(input int k, input logic [4:0] a);
    int unsigned ai;
    ai = a;
    if (ai >= dep[k]) return 64'd0;
    if (hz[k] != 0 && ai == zi[k]) return 64'd0;
    if (wr_en[1] && wr_addr[1] == a) return wr_data[1];
    if (wr_en[0] && wr_addr[0] == a) return wr_data[0];
    return mm[k][a];
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int k = 0; k < 3; k++) begin
          for (int a = 0; a < 32; a++) mm[k][a] = 64'd0;
          for (int i = 0; i < 2; i++) begin ed[k][i] = 64'd0; ev[k][i] = 1'b0; end
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) ed[k][i] = mval(k, rd_addr[i]);
            ev[k][i] = rd_en[i];
          end
          if (wr_en[1] && legal(k, wr_addr[1])) mm[k][wr_addr[1]] = wr_data[1];
          if (wr_en[0] && legal(k, wr_addr[0]) && !(wr_en[1] && wr_addr[1] == wr_addr[0]))
            mm[k][wr_addr[0]] = wr_data[0];
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        for (int k = 0; k < 3; k++) begin
          for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_data cfg%0d port%0d", k, i), rdd[k][i], ed[k][i]);
            chk($sformatf("model_valid cfg%0d port%0d", k, i), 64'(rdv[k][i]), 64'(ev[k][i]));
          end
        end
      end
    end
  end

  task automatic step(input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [1:0] wen, input logic [4:0] wa0, input logic [63:0] wd0,
                      input logic [4:0] wa1, input logic [63:0] wd1);
    rd_en = ren; rd_addr[0] = ra0; rd_addr[1] = ra1;
    wr_en = wen; wr_addr[0] = wa0; wr_data[0] = wd0; wr_addr[1] = wa1; wr_data[1] = wd1;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s data cfg%0d", name, k), 64'(rdd[k][0] | rdd[k][1]), 64'd0);
      chk($sformatf("%s valid cfg%0d", name, k), 64'(rdv[k]), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset_init");
    reset = 1'b0;

    // Async reset clears outputs and storage without a clock edge
    step(2'b00, 0, 0, 2'b01, 5, 64'h1234, 0, 0);
    step(2'b01, 5, 0, 2'b00, 0, 0, 0, 0);
    chk("r5_before_reset", rdd[0][0], 64'h1234);
    chk("r5_valid", 64'(rdv[0][0]), 64'd1);
    #3 reset = 1'b1;
    #1 chk_all_zero("reset_async");
    rd_en = 2'b11; rd_addr[0] = 5; rd_addr[1] = 6;
    wr_en = 2'b01; wr_addr[0] = 6; wr_data[0] = 64'h66;
    repeat (2) @(posedge clk);
    #2 chk_all_zero("reset_held");
    reset = 1'b0;
    step(2'b11, 5, 6, 2'b00, 0, 0, 0, 0);
    chk("r5_after_reset", rdd[0][0], 64'h0);
    chk("r6_write_in_reset", rdd[0][1], 64'h0);
    chk("valid_after_reset", 64'(rdv[0]), 64'd3);

    // Basic write then read
    step(2'b00, 0, 0, 2'b01, 3, 64'hDEAD, 0, 0);
    step(2'b01, 3, 0, 2'b00, 0, 0, 0, 0);
    chk("basic_rw", rdd[0][0], 64'hDEAD);
    chk("basic_valid", 64'(rdv[0]), 64'd1);

    // Write-first bypass on both ports
    step(2'b00, 0, 0, 2'b01, 7, 64'h11, 0, 0);
    step(2'b11, 7, 7, 2'b01, 7, 64'h22, 0, 0);
    chk("bypass_p0", rdd[0][0], 64'h22);
    chk("bypass_p1", rdd[0][1], 64'h22);
    step(2'b01, 7, 0, 2'b00, 0, 0, 0, 0);
    chk("bypass_stored", rdd[0][0], 64'h22);

    // Zero register, and the same address without a zero register
    step(2'b11, 31, 31, 2'b01, 31, 64'hFFFF, 0, 0);
    chk("zero_bypass", rdd[0][0], 64'h0);
    chk("nozero_bypass", rdd[1][1], 64'hFFFF);
    chk("oor31_depth24", rdd[2][0], 64'h0);
    step(2'b01, 31, 0, 2'b00, 0, 0, 0, 0);
    chk("zero_later", rdd[0][0], 64'h0);
    chk("nozero_later", rdd[1][0], 64'hFFFF);

    // Same-address write conflict: port 1 wins
    step(2'b11, 9, 9, 2'b11, 9, 64'hAA, 9, 64'hBB);
    chk("conflict_bypass", rdd[0][0], 64'hBB);
    chk("conflict_bypass_c", rdd[2][1], 64'hBB);
    step(2'b01, 9, 0, 2'b00, 0, 0, 0, 0);
    chk("conflict_stored", rdd[0][0], 64'hBB);

    // Hold with rd_en low while the address moves
    step(2'b00, 0, 0, 2'b01, 2, 64'h55, 0, 0);
    step(2'b01, 2, 0, 2'b00, 0, 0, 0, 0);
    chk("hold_load", rdd[2][0], 64'h55);
    for (int n = 0; n < 3; n++) begin
      step(2'b00, 5'(n * 4 + 1), 5'(n + 3), 2'b00, 0, 0, 0, 0);
      chk("hold_data", rdd[2][0], 64'h55);
      chk("hold_valid", 64'(rdv[2]), 64'd0);
    end

    // Out-of-range (depth 24) and zero-index writes are dropped
    step(2'b01, 30, 0, 2'b01, 30, 64'h77, 0, 0);
    chk("oor_read_c", rdd[2][0], 64'h0);
    chk("r30_bypass_a", rdd[0][0], 64'h77);
    step(2'b10, 0, 23, 2'b10, 0, 0, 23, 64'h99);
    chk("zero23_c", rdd[2][1], 64'h0);
    chk("r23_bypass_a", rdd[0][1], 64'h99);

    // Sweep every address; the per-cycle model check confirms nothing else changed
    for (int a = 0; a < 32; a += 2)
      step(2'b11, 5'(a), 5'(a + 1), 2'b00, 0, 0, 0, 0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
